fixed_p_std_div_pipe: RTL and testbench

Multi-cycle, synthesizable unsigned fixed-point divider using a restoring shift-subtract algorithm.
- Sits downstream of fixed_p_std_add/sub/mult in Calyx-generated datapaths and consumes their WIDTH-bit results.
- Replaces the unsynthesizable combinational divider in flows that need real hardware.
- Uses Calyx go/done handshake: one operation in flight, result held until the next accepted go.

---
 rtl/fixed_p_pkg.sv | 12 +
 rtl/fixed_p_std_div_pipe_if.sv | 24 ++
 rtl/fixed_p_div_step.sv | 21 ++
 rtl/fixed_p_std_div_pipe.sv | 125 ++++++++++++
 tb/tb_fixed_p_std_div_pipe.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_p_pkg.sv
// Shared types and helpers for the fixed-point Calyx-style arithmetic blocks.
package fixed_p_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;

  // Restoring division needs one step per bit of the widened dividend.
  function automatic int unsigned fp_div_iters(input int unsigned width,
                                               input int unsigned fract_width);
    return width + fract_width;
  endfunction

endpackage

// File: rtl/fixed_p_std_div_pipe_if.sv
// go/done handshake bundle for the multi-cycle fixed-point divider.
interface fixed_p_std_div_pipe_if #(
    parameter int unsigned WIDTH = 32
) ();

    logic             go;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             overflow;
    logic             done;

    modport master (
        output go, left, right,
        input  out_quotient, out_remainder, overflow, done
    );

    modport slave (
        input  go, left, right,
        output out_quotient, out_remainder, overflow, done
    );

endinterface

// File: rtl/fixed_p_div_step.sv
// One restoring shift-subtract step: shift in a dividend bit, subtract if it fits.
module fixed_p_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   remainder,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   remainder_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;

    always_comb begin
        shifted = {remainder[WIDTH-1:0], din};
        // A set top bit means the shifted value already exceeds any divisor.
        q_bit = remainder[WIDTH] | (shifted >= {1'b0, divisor});
        remainder_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;
    end

endmodule

// File: rtl/fixed_p_std_div_pipe.sv
// Multi-cycle unsigned fixed-point divider, restoring algorithm, Calyx go/done handshake.
module fixed_p_std_div_pipe
    import fixed_p_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned INT_WIDTH   = 8,
    parameter int unsigned FRACT_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    fixed_p_std_div_pipe_if.slave bus
);

    localparam int unsigned N  = fp_div_iters(WIDTH, FRACT_WIDTH);
    localparam int unsigned CW = $clog2(N + 1);

    if (WIDTH != INT_WIDTH + FRACT_WIDTH) begin : g_width_check
        $error("fixed_p_std_div_pipe: WIDTH must equal INT_WIDTH + FRACT_WIDTH");
    end

    div_state_t       state_q, state_d;
    // Dividend bits shift out the top while quotient bits fill in from the bottom.
    logic [N-1:0]     dvd_q, dvd_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   step_rem;
    logic             step_q;

    fixed_p_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .remainder      (rem_q),
        .din            (dvd_q[N-1]),
        .divisor        (div_q),
        .remainder_next (step_rem),
        .q_bit          (step_q)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            rem_q     <= '0;
            div_q     <= '0;
            left_q    <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            quot_q    <= '0;
            rem_out_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            rem_q     <= rem_d;
            div_q     <= div_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
            quot_q    <= quot_d;
            rem_out_q <= rem_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        rem_d     = rem_q;
        div_d     = div_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        zero_d    = zero_q;
        quot_d    = quot_q;
        rem_out_d = rem_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.go) begin
                    dvd_d   = {bus.left, {FRACT_WIDTH{1'b0}}};
                    div_d   = bus.right;
                    left_d  = bus.left;
                    rem_d   = '0;
                    cnt_d   = CW'(N);
                    zero_d  = (bus.right == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[N-2:0], step_q};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d    = 1'b1;
                quot_d    = zero_q ? '1 : dvd_q[WIDTH-1:0];
                rem_out_d = zero_q ? left_q : rem_q[WIDTH-1:0];
                ovf_d     = zero_q | (|dvd_q[N-1:WIDTH]);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_quotient  = quot_q;
    assign bus.out_remainder = rem_out_q;
    assign bus.overflow      = ovf_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Directed bench for fixed_p_std_div_pipe at 8/4/4 and default 32/8/24 configurations.
module tb_fixed_p_std_div_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fixed_p_std_div_pipe_if #(.WIDTH(8))  if8 ();
    fixed_p_std_div_pipe_if #(.WIDTH(32)) if32 ();

    fixed_p_std_div_pipe #(
        .WIDTH       (8),
        .INT_WIDTH   (4),
        .FRACT_WIDTH (4)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8)
    );

    fixed_p_std_div_pipe #(
        .WIDTH       (32),
        .INT_WIDTH   (8),
        .FRACT_WIDTH (24)
    ) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (if32)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic start8(input logic [7:0] l, input logic [7:0] r);
        @(negedge clk);
        if8.left  = l;
        if8.right = r;
        if8.go    = 1'b1;
        @(posedge clk);
        #1;
        if8.go = 1'b0;
    endtask

    task automatic start32(input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        if32.left  = l;
        if32.right = r;
        if32.go    = 1'b1;
        @(posedge clk);
        #1;
        if32.go = 1'b0;
    endtask

    // Counts edges until done is seen; n0 is the number already consumed.
    task automatic wait8(input int n0, output int n);
        n = n0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (if8.done) break;
        end
    endtask

    task automatic wait32(input int n0, output int n);
        n = n0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (if32.done) break;
        end
    endtask

    task automatic count_done32(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (if32.done) hits++;
        end
    endtask

    initial begin
        int n;
        int hits;

        if8.go = 1'b0;  if8.left = '0;  if8.right = '0;
        if32.go = 1'b0; if32.left = '0; if32.right = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_q32", if32.out_quotient, 32'h0);
        check("rst_r32", if32.out_remainder, 32'h0);
        check("rst_ovf32", 32'(if32.overflow), 32'h0);
        check("rst_done32", 32'(if32.done), 32'h0);
        check("rst_done8", 32'(if8.done), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // 3.0 / 2.0 = 1.5 in Q4.4
        start8(8'h30, 8'h20);
        wait8(0, n);
        check("lat8_a", 32'(n), 32'd13);
        check("q8_a", 32'(if8.out_quotient), 32'h18);
        check("r8_a", 32'(if8.out_remainder), 32'h00);
        check("ovf8_a", 32'(if8.overflow), 32'h0);
        @(posedge clk);
        #1;
        check("pulse8_a", 32'(if8.done), 32'h0);
        check("hold8_a", 32'(if8.out_quotient), 32'h18);

        // 1.0 / 3.0: 0x100 / 0x30 = 5 rem 0x10
        start8(8'h10, 8'h30);
        wait8(0, n);
        check("q8_b", 32'(if8.out_quotient), 32'h05);
        check("r8_b", 32'(if8.out_remainder), 32'h10);
        check("ovf8_b", 32'(if8.overflow), 32'h0);

        // 15.9375 / 0.0625 = 255.0, integer part overflows
        start8(8'hFF, 8'h01);
        wait8(0, n);
        check("q8_c", 32'(if8.out_quotient), 32'hF0);
        check("r8_c", 32'(if8.out_remainder), 32'h00);
        check("ovf8_c", 32'(if8.overflow), 32'h1);

        // 1.0 / 3.0 with a stray go and operand change mid-run
        start32(32'h0100_0000, 32'h0300_0000);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if32.go    = 1'b1;
        if32.left  = 32'hFFFF_FFFF;
        if32.right = 32'h0000_0001;
        @(posedge clk);
        #1;
        if32.go = 1'b0;
        wait32(11, n);
        check("lat32_a", 32'(n), 32'd57);
        check("q32_a", if32.out_quotient, 32'h0055_5555);
        check("r32_a", if32.out_remainder, 32'h0100_0000);
        check("ovf32_a", 32'(if32.overflow), 32'h0);
        @(posedge clk);
        #1;
        check("pulse32_a", 32'(if32.done), 32'h0);

        // 255.0 / 0.5 = 510.0 overflows
        start32(32'hFF00_0000, 32'h0080_0000);
        wait32(0, n);
        check("q32_b", if32.out_quotient, 32'hFE00_0000);
        check("r32_b", if32.out_remainder, 32'h0);
        check("ovf32_b", 32'(if32.overflow), 32'h1);

        // divide by zero
        start32(32'h1234_5678, 32'h0);
        wait32(0, n);
        check("lat32_z", 32'(n), 32'd57);
        check("q32_z", if32.out_quotient, 32'hFFFF_FFFF);
        check("r32_z", if32.out_remainder, 32'h1234_5678);
        check("ovf32_z", 32'(if32.overflow), 32'h1);

        // reset mid-run discards the operation
        start32(32'h0100_0000, 32'h0300_0000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_q", if32.out_quotient, 32'h0);
        check("mrst_r", if32.out_remainder, 32'h0);
        check("mrst_ovf", 32'(if32.overflow), 32'h0);
        check("mrst_done", 32'(if32.done), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        count_done32(70, hits);
        check("mrst_nodone", 32'(hits), 32'd0);
        start32(32'h0200_0000, 32'h0100_0000);
        wait32(0, n);
        check("lat32_c", 32'(n), 32'd57);
        check("q32_c", if32.out_quotient, 32'h0200_0000);
        check("r32_c", if32.out_remainder, 32'h0);

        // go held high: back-to-back operations, operands latched at go
        @(negedge clk);
        if32.left  = 32'h0100_0000;
        if32.right = 32'h0300_0000;
        if32.go    = 1'b1;
        @(posedge clk);
        #1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if32.left  = 32'h0200_0000;
        if32.right = 32'h0100_0000;
        wait32(20, n);
        check("b2b_lat1", 32'(n), 32'd57);
        check("b2b_q1", if32.out_quotient, 32'h0055_5555);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if32.left  = 32'h1234_5678;
        if32.right = 32'h0;
        wait32(20, n);
        if32.go = 1'b0;
        check("b2b_period", 32'(n), 32'd58);
        check("b2b_q2", if32.out_quotient, 32'h0200_0000);
        check("b2b_r2", if32.out_remainder, 32'h0);
        check("b2b_ovf2", 32'(if32.overflow), 32'h0);
        count_done32(70, hits);
        check("b2b_stop", 32'(hits), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
